// File: rtl/addpkg.sv
// Shared types and constants for the FP add/subtract datapath.
//   o_err_t        : error code reported by add_sub_top (0 = no error)
//   fp_seq_state_t : issue/capture sequencer states
//   FP_*_W         : single-precision field widths and destination tag width
package addpkg;

  typedef logic [2:0] o_err_t;

  localparam int unsigned FP_EXP_W  = 8;
  localparam int unsigned FP_FRAC_W = 23;
  localparam int unsigned FP_TAG_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } fp_seq_state_t;

endpackage

// File: rtl/fp_addsub_seq_if.sv
// Operand/result handshake bundle for fp_addsub_seq.
//   in_valid/in_ready   : operand pair handshake (in_op, in_a, in_b, in_tag)
//   out_valid/out_ready : result handshake (out_result, out_err, out_tag)
// master = operand producer / result consumer, slave = the sequencer.
interface fp_addsub_seq_if;
  import addpkg::*;

  logic                in_valid;
  logic                in_ready;
  logic                in_op;
  logic [31:0]         in_a;
  logic [31:0]         in_b;
  logic [FP_TAG_W-1:0] in_tag;

  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out_result;
  o_err_t              out_err;
  logic [FP_TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_err, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_err, out_tag
  );

endinterface

// File: rtl/fp_addsub_seq.sv
// Issue/capture sequencer for the combinational add_sub_top FP adder.
// Accepts an operand pair, presents registered sign/exponent/fraction fields
// to add_sub_top for EXEC_CYCLES cycles, then captures fp_out/err_o into a
// result register held until the consumer accepts it.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   bus (slave)       : operand and result valid/ready handshakes
//   sign1..sig2,opcode: registered operand fields to add_sub_top
//   fp_out, err_o     : add_sub_top result and error code
//   flags_clr         : synchronous clear of err_sticky
//   err_sticky        : bit n set once a captured err_o equalled n (n=1..7)
module fp_addsub_seq
  import addpkg::*;
#(
  parameter int unsigned EXEC_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  fp_addsub_seq_if.slave       bus,
  output logic                 sign1,
  output logic                 sign2,
  output logic [FP_EXP_W-1:0]  exp1,
  output logic [FP_EXP_W-1:0]  exp2,
  output logic [FP_FRAC_W-1:0] sig1,
  output logic [FP_FRAC_W-1:0] sig2,
  output logic                 opcode,
  input  logic [31:0]          fp_out,
  input  o_err_t               err_o,
  input  logic                 flags_clr,
  output logic [7:0]           err_sticky
);

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  fp_seq_state_t       state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [31:0]         a_q, a_d, b_q, b_d;
  logic                op_q, op_d;
  logic [FP_TAG_W-1:0] tag_q, tag_d;
  logic [31:0]         res_q, res_d;
  o_err_t              err_q, err_d;
  logic [FP_TAG_W-1:0] otag_q, otag_d;
  logic [7:0]          sticky_q, sticky_d;
  logic                accept;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    a_d           = a_q;
    b_d           = b_q;
    op_d          = op_q;
    tag_d         = tag_q;
    res_d         = res_q;
    err_d         = err_q;
    otag_d        = otag_q;
    // Clear first, so a capture in the same cycle still lands its bit.
    sticky_d      = flags_clr ? '0 : sticky_q;
    accept        = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          res_d   = fp_out;
          err_d   = err_o;
          otag_d  = tag_q;
          if (err_o != '0) sticky_d[err_o] = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        // Pass-through ready lets the next op issue as this result drains.
        bus.in_ready  = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            accept  = 1'b1;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      a_d   = bus.in_a;
      b_d   = bus.in_b;
      op_d  = bus.in_op;
      tag_d = bus.in_tag;
      cnt_d = CNT_INIT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      tag_q    <= '0;
      res_q    <= '0;
      err_q    <= '0;
      otag_q   <= '0;
      sticky_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
      res_q    <= res_d;
      err_q    <= err_d;
      otag_q   <= otag_d;
      sticky_q <= sticky_d;
    end
  end

  assign sign1          = a_q[31];
  assign exp1           = a_q[30:23];
  assign sig1           = a_q[22:0];
  assign sign2          = b_q[31];
  assign exp2           = b_q[30:23];
  assign sig2           = b_q[22:0];
  assign opcode         = op_q;
  assign bus.out_result = res_q;
  assign bus.out_err    = err_q;
  assign bus.out_tag    = otag_q;
  assign err_sticky     = sticky_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Bench for fp_addsub_seq: three instances (EXEC_CYCLES = 2, 1, 3), each with
// a stub add_sub_top that handles integer-valued single-precision operands.
module tb_fp_addsub_seq;
  import addpkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]       iv, iop, ordy, fclr, irdy, ov, s1v, s2v, opv;
  logic [2:0][31:0] ia, ib, ores;
  logic [2:0][4:0]  itag, otag;
  logic [2:0][2:0]  estub, oerr;
  logic [2:0][7:0]  e1v, e2v, sticky;
  logic [2:0][22:0] f1v, f2v;

  int tests = 0;
  int fails = 0;

  // Integer -> single-precision bits (exact for |v| < 2^24).
  function automatic logic [31:0] enc(input int v);
    int m;
    int p;
    logic [31:0] r;
    if (v == 0) return '0;
    m = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 24; i++) if (m >= (1 << i)) p = i;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + p);
    r[22:0]  = 23'((m << (23 - p)) & 32'h007F_FFFF);
    return r;
  endfunction

  // Single-precision fields -> integer (integer-valued operands only).
  function automatic int dec(input logic s, input logic [7:0] e, input logic [22:0] f);
    int m;
    if (e < 8'd127 || e > 8'd150) return 0;
    m = int'({1'b1, f}) >> (150 - int'(e));
    return s ? -m : m;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    localparam int unsigned EC = (gi == 0) ? 2 : ((gi == 1) ? 1 : 3);
    fp_addsub_seq_if bus ();
    logic [31:0] fpo;
    o_err_t      eo;

    assign bus.in_valid  = iv[gi];
    assign bus.in_op     = iop[gi];
    assign bus.in_a      = ia[gi];
    assign bus.in_b      = ib[gi];
    assign bus.in_tag    = itag[gi];
    assign bus.out_ready = ordy[gi];
    assign irdy[gi]      = bus.in_ready;
    assign ov[gi]        = bus.out_valid;
    assign ores[gi]      = bus.out_result;
    assign oerr[gi]      = bus.out_err;
    assign otag[gi]      = bus.out_tag;

    fp_addsub_seq #(.EXEC_CYCLES(EC)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .sign1      (s1v[gi]),
      .sign2      (s2v[gi]),
      .exp1       (e1v[gi]),
      .exp2       (e2v[gi]),
      .sig1       (f1v[gi]),
      .sig2       (f2v[gi]),
      .opcode     (opv[gi]),
      .fp_out     (fpo),
      .err_o      (eo),
      .flags_clr  (fclr[gi]),
      .err_sticky (sticky[gi])
    );

    assign fpo = opv[gi] ? enc(dec(s1v[gi], e1v[gi], f1v[gi]) - dec(s2v[gi], e2v[gi], f2v[gi]))
                         : enc(dec(s1v[gi], e1v[gi], f1v[gi]) + dec(s2v[gi], e2v[gi], f2v[gi]));
    assign eo  = estub[gi];
  end

  task automatic test_reset();
    #1;
    tests++;
    if ({ov[0], irdy[0], ores[0], oerr[0], otag[0], sticky[0]} !== {1'b0, 1'b1, 32'h0, 3'h0, 5'h0, 8'h0}) begin
      fails++;
      $display("FAIL reset_out: got v=%b r=%b res=%h err=%h tag=%h st=%h, exp v=0 r=1 rest 0",
               ov[0], irdy[0], ores[0], oerr[0], otag[0], sticky[0]);
    end
    tests++;
    if ({s1v[0], e1v[0], f1v[0], s2v[0], e2v[0], f2v[0], opv[0]} !== '0) begin
      fails++;
      $display("FAIL reset_fields: got e1=%h f1=%h e2=%h f2=%h, exp 0", e1v[0], f1v[0], e2v[0], f2v[0]);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({ov[0], irdy[0]} !== 2'b01) begin
      fails++;
      $display("FAIL reset_release: got v=%b r=%b, exp v=0 r=1", ov[0], irdy[0]);
    end
  endtask

  task automatic test_add();
    iv[0] = 1'b1; ia[0] = 32'h3F80_0000; ib[0] = 32'h4000_0000; iop[0] = 1'b0; itag[0] = 5'd9;
    #1;
    tests++;
    if (irdy[0] !== 1'b1) begin
      fails++;
      $display("FAIL add_ready: got %b exp 1", irdy[0]);
    end
    @(negedge clk);
    iv[0] = 1'b0;
    tests++;
    if (ov[0] !== 1'b0) begin fails++; $display("FAIL add_lat1: out_valid got %b exp 0", ov[0]); end
    @(negedge clk);
    tests++;
    if (ov[0] !== 1'b0) begin fails++; $display("FAIL add_lat2: out_valid got %b exp 0", ov[0]); end
    @(negedge clk);
    tests++;
    if ({ov[0], ores[0], oerr[0], otag[0]} !== {1'b1, 32'h4040_0000, 3'd0, 5'd9}) begin
      fails++;
      $display("FAIL add_result: got v=%b res=%h err=%h tag=%0d, exp v=1 res=40400000 err=0 tag=9",
               ov[0], ores[0], oerr[0], otag[0]);
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;
    tests++;
    if (ov[0] !== 1'b0) begin fails++; $display("FAIL add_drain: out_valid got %b exp 0", ov[0]); end
  endtask

  task automatic test_sub();
    iv[0] = 1'b1; ia[0] = 32'h4040_0000; ib[0] = 32'h3F80_0000; iop[0] = 1'b1; itag[0] = 5'd17;
    @(negedge clk);
    iv[0] = 1'b0;
    tests++;
    if ({s1v[0], e1v[0], f1v[0], opv[0]} !== {1'b0, 8'h80, 23'h40_0000, 1'b1}) begin
      fails++;
      $display("FAIL sub_fields: got s1=%b e1=%h f1=%h op=%b, exp s1=0 e1=80 f1=400000 op=1",
               s1v[0], e1v[0], f1v[0], opv[0]);
    end
    repeat (2) @(negedge clk);
    tests++;
    if ({ov[0], ores[0], otag[0]} !== {1'b1, 32'h4000_0000, 5'd17}) begin
      fails++;
      $display("FAIL sub_result: got v=%b res=%h tag=%0d, exp v=1 res=40000000 tag=17", ov[0], ores[0], otag[0]);
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;
  endtask

  task automatic test_back_to_back();
    // 5.0 + 3.0 = 8.0
    iv[0] = 1'b1; ia[0] = 32'h40A0_0000; ib[0] = 32'h4040_0000; iop[0] = 1'b0; itag[0] = 5'd3;
    @(negedge clk);
    // Next op (1.0 + 1.0) offered while the first is busy and then stalled.
    ia[0] = 32'h3F80_0000; ib[0] = 32'h3F80_0000; itag[0] = 5'd4;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++;
      if ({ov[0], irdy[0], ores[0], otag[0]} !== {1'b1, 1'b0, 32'h4100_0000, 5'd3}) begin
        fails++;
        $display("FAIL bp_hold%0d: got v=%b r=%b res=%h tag=%0d, exp v=1 r=0 res=41000000 tag=3",
                 i, ov[0], irdy[0], ores[0], otag[0]);
      end
      @(negedge clk);
    end
    ordy[0] = 1'b1;
    #1;
    tests++;
    if (irdy[0] !== 1'b1) begin fails++; $display("FAIL b2b_ready: got %b exp 1", irdy[0]); end
    @(negedge clk);
    iv[0] = 1'b0; ordy[0] = 1'b0;
    tests++;
    if (ov[0] !== 1'b0) begin fails++; $display("FAIL b2b_lat1: out_valid got %b exp 0", ov[0]); end
    @(negedge clk);
    tests++;
    if (ov[0] !== 1'b0) begin fails++; $display("FAIL b2b_lat2: out_valid got %b exp 0", ov[0]); end
    @(negedge clk);
    tests++;
    if ({ov[0], ores[0], otag[0]} !== {1'b1, 32'h4000_0000, 5'd4}) begin
      fails++;
      $display("FAIL b2b_result: got v=%b res=%h tag=%0d, exp v=1 res=40000000 tag=4", ov[0], ores[0], otag[0]);
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;
  endtask

  // Issue one op on instance 0 and drain it; bounded wait for out_valid.
  task automatic run_op0(input logic [31:0] a, input logic [31:0] b, input logic [2:0] err);
    int n;
    estub[0] = err; iv[0] = 1'b1; ia[0] = a; ib[0] = b; iop[0] = 1'b0; itag[0] = 5'd1;
    @(negedge clk);
    iv[0] = 1'b0;
    n = 0;
    while (ov[0] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n == 20) begin fails++; tests++; $display("FAIL run_op_timeout: out_valid got 0 exp 1"); end
    ordy[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;
  endtask

  task automatic test_sticky();
    fclr[0] = 1'b1;
    @(negedge clk);
    fclr[0] = 1'b0;
    run_op0(32'h3F80_0000, 32'h3F80_0000, 3'd3);
    run_op0(32'h3F80_0000, 32'h3F80_0000, 3'd0);
    tests++;
    if (sticky[0] !== 8'h08) begin fails++; $display("FAIL sticky_accum: got %h exp 08", sticky[0]); end
    estub[0] = 3'd5; iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    tests++;
    if (sticky[0] !== 8'h08) begin fails++; $display("FAIL sticky_pre_clr: got %h exp 08", sticky[0]); end
    fclr[0] = 1'b1;
    @(negedge clk);
    fclr[0] = 1'b0;
    tests++;
    if ({ov[0], oerr[0], sticky[0]} !== {1'b1, 3'd5, 8'h20}) begin
      fails++;
      $display("FAIL sticky_clr_capture: got v=%b err=%0d st=%h, exp v=1 err=5 st=20", ov[0], oerr[0], sticky[0]);
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0; estub[0] = 3'd0;
  endtask

  task automatic test_reset_mid();
    iv[0] = 1'b1; ia[0] = 32'h4040_0000; ib[0] = 32'hC0A0_0000; iop[0] = 1'b0; itag[0] = 5'd30;
    @(negedge clk);
    iv[0] = 1'b0;
    rst = 1'b1;
    #1;
    tests++;
    if ({ov[0], irdy[0], sticky[0]} !== {1'b0, 1'b1, 8'h00}) begin
      fails++;
      $display("FAIL rstmid_ctrl: got v=%b r=%b st=%h, exp v=0 r=1 st=00", ov[0], irdy[0], sticky[0]);
    end
    tests++;
    if ({s1v[0], e1v[0], f1v[0], s2v[0], e2v[0], f2v[0], opv[0]} !== '0) begin
      fails++;
      $display("FAIL rstmid_fields: got s2=%b e1=%h e2=%h f2=%h, exp 0", s2v[0], e1v[0], e2v[0], f2v[0]);
    end
    #2 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if ({ov[0], ores[0]} !== {1'b0, 32'h0}) begin
        fails++;
        $display("FAIL rstmid_stale%0d: got v=%b res=%h, exp v=0 res=0", i, ov[0], ores[0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_scoreboard(input int idx, input int nops);
    logic [39:0] q[$];
    logic [39:0] expv;
    int issued, recv, cyc, va, vb;
    logic cop, have;
    logic [2:0] cerr;
    logic [7:0] exp_st;
    issued = 0; recv = 0; cyc = 0; va = 0; vb = 0; cop = 1'b0; have = 1'b0; cerr = '0; exp_st = '0;
    while ((issued < nops || recv < nops) && cyc < 4000) begin
      if (!have && issued < nops) begin
        va = int'($urandom_range(1, 200)); if ($urandom_range(0, 1) == 1) va = -va;
        vb = int'($urandom_range(1, 200)); if ($urandom_range(0, 1) == 1) vb = -vb;
        cop = 1'($urandom_range(0, 1));
        cerr = 3'($urandom_range(0, 7));
        have = 1'b1;
      end
      iv[idx]   = have && ($urandom_range(0, 3) != 0);
      ordy[idx] = ($urandom_range(0, 2) != 0);
      ia[idx] = enc(va); ib[idx] = enc(vb); iop[idx] = cop; itag[idx] = 5'(issued);
      #1;
      if (ov[idx] && ordy[idx]) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL sb%0d_extra: got unexpected res=%h tag=%0d", idx, ores[idx], otag[idx]);
        end else begin
          expv = q.pop_front();
          if ({ores[idx], oerr[idx], otag[idx]} !== expv) begin
            fails++;
            $display("FAIL sb%0d_result: got res=%h err=%0d tag=%0d, exp res=%h err=%0d tag=%0d",
                     idx, ores[idx], oerr[idx], otag[idx], expv[39:8], expv[7:5], expv[4:0]);
          end
        end
        recv++;
      end
      if (iv[idx] && irdy[idx]) begin
        estub[idx] = cerr;
        q.push_back({enc(cop ? (va - vb) : (va + vb)), cerr, 5'(issued)});
        if (cerr != 3'd0) exp_st[cerr] = 1'b1;
        issued++;
        have = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    iv[idx] = 1'b0; ordy[idx] = 1'b0;
    tests++;
    if (recv != nops || q.size() != 0) begin
      fails++;
      $display("FAIL sb%0d_count: got recv=%0d pending=%0d, exp recv=%0d pending=0", idx, recv, q.size(), nops);
    end
    tests++;
    if (sticky[idx] !== exp_st) begin
      fails++;
      $display("FAIL sb%0d_sticky: got %h exp %h", idx, sticky[idx], exp_st);
    end
  endtask

  initial begin
    iv = '0; iop = '0; ia = '0; ib = '0; itag = '0; ordy = '0; fclr = '0; estub = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_sticky();
    test_reset_mid();
    test_scoreboard(1, 40);
    test_scoreboard(2, 40);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
